// File: rtl/dcm_prog_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// dcm_prog_scheduler_pkg
// Purpose : Shared definitions for the DCM_CLKGEN programming scheduler:
//           FSM state encoding, LoadD/LoadM command codes, shift frame length,
//           and small helpers used by the top and the round-robin arbiter.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package dcm_prog_scheduler_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_D,
        ST_GAP1,
        ST_LOAD_M,
        ST_GAP2,
        ST_GO,
        ST_WAIT_DONE,
        ST_WAIT_LOCK,
        ST_DONE
    } state_t;

    // Command codes are shifted out bit0 first, ahead of the 8-bit value.
    localparam logic [1:0] CMD_LOADD = 2'b01;
    localparam logic [1:0] CMD_LOADM = 2'b11;

    localparam int         SHIFT_LEN = 10;
    localparam logic [3:0] BIT_LAST  = 4'(SHIFT_LEN - 1);

    // Pointer width that stays legal for a single requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One programming frame: command then value, LSB first on the wire.
    function automatic logic [SHIFT_LEN-1:0] make_frame(input logic [1:0] cmd,
                                                        input logic [7:0] val);
        return {val, cmd};
    endfunction

endpackage

// File: rtl/dcm_prog_rr_arb.sv
// -----------------------------------------------------------------------------
// dcm_prog_rr_arb
// Purpose : Combinational round-robin arbiter. Grants the first active request
//           at or after the pointer, wrapping to index 0.
// Ports   : i_req       in  NUM_DCM  request vector
//           i_ptr       in  PTR_W    round-robin start index
//           o_grant     out NUM_DCM  one-hot grant (zero when no request)
//           o_grant_idx out PTR_W    binary index of the grant
//           o_grant_vld out 1        any request granted
// -----------------------------------------------------------------------------
module dcm_prog_rr_arb
    import dcm_prog_scheduler_pkg::*;
#(
    parameter  int NUM_DCM = 2,
    localparam int PTR_W   = ptr_width(NUM_DCM)
) (
    input  logic [NUM_DCM-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_DCM-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_grant_vld
);

    // NOTE: every output gets a default before the search loops so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        // First pass: requesters at or above the pointer.
        for (int i = 0; i < NUM_DCM; i++) begin
            if (!o_grant_vld && i_req[i] && (i >= int'(i_ptr))) begin
                o_grant[i]  = 1'b1;
                o_grant_idx = PTR_W'(i);
                o_grant_vld = 1'b1;
            end
        end
        // Second pass: wrap around to the lowest index.
        for (int i = 0; i < NUM_DCM; i++) begin
            if (!o_grant_vld && i_req[i]) begin
                o_grant[i]  = 1'b1;
                o_grant_idx = PTR_W'(i);
                o_grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcm_prog_scheduler.sv
// -----------------------------------------------------------------------------
// dcm_prog_scheduler
// Purpose : Shares one DCM_CLKGEN programming serializer among NUM_DCM clock
//           generators. Arbitrates requests round-robin, shifts LoadD, LoadM and
//           GO onto PROGEN/PROGDATA, waits for PROGDONE then LOCKED under a
//           watchdog, and pulses ack (with err) to the requester.
// Ports   : clk       in  1          programming clock (also PROGCLK)
//           rst       in  1          asynchronous reset, active high
//           req       in  NUM_DCM    level requests, held until ack
//           mul_m1    in  8*NUM_DCM  M-1 per requester (legal 1..255)
//           div_m1    in  8*NUM_DCM  D-1 per requester
//           ack       out NUM_DCM    one-cycle completion pulse
//           err       out 1          valid with ack: bad M-1 or watchdog expiry
//           busy      out 1          grant through ack cycle
//           progen    out NUM_DCM    PROGEN, only the granted bit can be high
//           progdata  out 1          shared PROGDATA
//           progdone  in  NUM_DCM    PROGDONE per DCM
//           locked    in  NUM_DCM    LOCKED per DCM
// -----------------------------------------------------------------------------
module dcm_prog_scheduler
    import dcm_prog_scheduler_pkg::*;
#(
    parameter int NUM_DCM   = 2,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_DCM-1:0]   req,
    input  logic [8*NUM_DCM-1:0] mul_m1,
    input  logic [8*NUM_DCM-1:0] div_m1,
    output logic [NUM_DCM-1:0]   ack,
    output logic                 err,
    output logic                 busy,
    output logic [NUM_DCM-1:0]   progen,
    output logic                 progdata,
    input  logic [NUM_DCM-1:0]   progdone,
    input  logic [NUM_DCM-1:0]   locked
);

    localparam int PTR_W = ptr_width(NUM_DCM);
    // One count short of all-ones: the watchdog hits all-ones on the exit edge.
    localparam logic [TIMEOUT_W-1:0] WDOG_ARM = ~TIMEOUT_W'(1);

    state_t                 r_state;
    logic [NUM_DCM-1:0]     r_grant;
    logic [PTR_W-1:0]       r_ptr;
    logic [7:0]             r_mul;
    logic [SHIFT_LEN-1:0]   r_shift;
    logic [3:0]             r_bitcnt;
    logic [TIMEOUT_W-1:0]   r_wdog;
    logic [NUM_DCM-1:0]     r_ack;
    logic                   r_err;
    logic                   r_busy;
    logic [NUM_DCM-1:0]     r_progen;
    logic                   r_progdata;

    logic [NUM_DCM-1:0]     w_grant;
    logic [PTR_W-1:0]       w_grant_idx;
    logic                   w_grant_vld;
    logic [PTR_W-1:0]       w_ptr_next;
    logic [7:0]             w_mul_sel;
    logic [7:0]             w_div_sel;
    logic [SHIFT_LEN-1:0]   w_frame_d;
    logic [SHIFT_LEN-1:0]   w_frame_m;
    logic                   w_done_g;
    logic                   w_lock_g;
    logic                   w_wdog_exp;

    dcm_prog_rr_arb #(
        .NUM_DCM (NUM_DCM)
    ) u_arb (
        .i_req       (req),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld)
    );

    // Select the grantee's M-1/D-1 slices.
    always_comb begin
        w_mul_sel = '0;
        w_div_sel = '0;
        for (int i = 0; i < NUM_DCM; i++) begin
            if (w_grant_idx == PTR_W'(i)) begin
                w_mul_sel = mul_m1[8*i +: 8];
                w_div_sel = div_m1[8*i +: 8];
            end
        end
    end

    assign w_ptr_next = (w_grant_idx == PTR_W'(NUM_DCM - 1)) ? '0 : w_grant_idx + 1'b1;
    assign w_frame_d  = make_frame(CMD_LOADD, w_div_sel);
    assign w_frame_m  = make_frame(CMD_LOADM, r_mul);
    // Status from non-granted DCMs is masked off.
    assign w_done_g   = |(progdone & r_grant);
    assign w_lock_g   = |(locked & r_grant);
    assign w_wdog_exp = (r_wdog >= WDOG_ARM);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_mul      <= '0;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_wdog     <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_progen   <= '0;
            r_progdata <= 1'b0;
        end else begin
            // ack/err are single-cycle pulses unless a branch sets them.
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_grant <= w_grant;
                        r_ptr   <= w_ptr_next;
                        r_mul   <= w_mul_sel;
                        r_busy  <= 1'b1;
                        if (w_mul_sel == 8'd0) begin
                            r_state <= ST_DONE;
                            r_ack   <= w_grant;
                            r_err   <= 1'b1;
                        end else begin
                            r_state    <= ST_LOAD_D;
                            r_progen   <= w_grant;
                            r_progdata <= w_frame_d[0];
                            r_shift    <= w_frame_d >> 1;
                            r_bitcnt   <= '0;
                        end
                    end
                end
                ST_LOAD_D, ST_LOAD_M: begin
                    if (r_bitcnt == BIT_LAST) begin
                        r_state    <= (r_state == ST_LOAD_D) ? ST_GAP1 : ST_GAP2;
                        r_progen   <= '0;
                        r_progdata <= 1'b0;
                    end else begin
                        r_progdata <= r_shift[0];
                        r_shift    <= r_shift >> 1;
                        r_bitcnt   <= r_bitcnt + 1'b1;
                    end
                end
                ST_GAP1: begin
                    r_state    <= ST_LOAD_M;
                    r_progen   <= r_grant;
                    r_progdata <= w_frame_m[0];
                    r_shift    <= w_frame_m >> 1;
                    r_bitcnt   <= '0;
                end
                ST_GAP2: begin
                    r_state    <= ST_GO;
                    r_progen   <= r_grant;
                    r_progdata <= 1'b0;
                end
                ST_GO: begin
                    r_state  <= ST_WAIT_DONE;
                    r_progen <= '0;
                    r_wdog   <= '0;
                end
                ST_WAIT_DONE, ST_WAIT_LOCK: begin
                    if (r_wdog != '1) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                    if ((r_state == ST_WAIT_DONE) && w_done_g) begin
                        r_state <= ST_WAIT_LOCK;
                    end else if ((r_state == ST_WAIT_LOCK) && w_lock_g) begin
                        r_state <= ST_DONE;
                        r_ack   <= r_grant;
                    end else if (w_wdog_exp) begin
                        r_state <= ST_DONE;
                        r_ack   <= r_grant;
                        r_err   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_grant  <= '0;
                    r_busy   <= 1'b0;
                    r_progen <= '0;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign busy     = r_busy;
    assign progen   = r_progen;
    assign progdata = r_progdata;

endmodule

// File: tb/tb_dcm_prog_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dcm_prog_scheduler
// Purpose : Directed self-checking bench for dcm_prog_scheduler (NUM_DCM=2,
//           TIMEOUT_W=4). Expected acks live in a scoreboard queue and are
//           popped whenever the DUT pulses ack.
// -----------------------------------------------------------------------------
module tb_dcm_prog_scheduler;

    localparam int NUM_DCM   = 2;
    localparam int TIMEOUT_W = 4;
    localparam int SHIFT_CYC = 23;

    logic                 clk;
    logic                 rst;
    logic [NUM_DCM-1:0]   req;
    logic [8*NUM_DCM-1:0] mul_m1;
    logic [8*NUM_DCM-1:0] div_m1;
    logic [NUM_DCM-1:0]   ack;
    logic                 err;
    logic                 busy;
    logic [NUM_DCM-1:0]   progen;
    logic                 progdata;
    logic [NUM_DCM-1:0]   progdone;
    logic [NUM_DCM-1:0]   locked;

    typedef struct {
        logic [NUM_DCM-1:0] onehot;
        logic               err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic ack_seen;
    logic [NUM_DCM-1:0] progen_or;

    dcm_prog_scheduler #(
        .NUM_DCM   (NUM_DCM),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .mul_m1   (mul_m1),
        .div_m1   (div_m1),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .progen   (progen),
        .progdata (progdata),
        .progdone (progdone),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and look at outputs 1 ns after the edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        progen_or = progen_or | progen;
        check("progen_onehot", 32'($countones(progen) <= 1), 1);
        if (ack !== '0) begin
            ack_seen = 1'b1;
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'(ack), 0);
            end else begin
                e = sb_q.pop_front();
                check("ack_idx", 32'(ack), 32'(e.onehot));
                check("ack_err", 32'(err), 32'(e.err));
            end
        end else begin
            ack_seen = 1'b0;
        end
    endtask

    task automatic wait_ack(input string tag, input int bound, output int n);
        n = 0;
        ack_seen = 1'b0;
        while (!ack_seen && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_ack_seen"}, 32'(ack_seen), 1);
    endtask

    // Record progen[idx]/progdata for the 23 shift-phase cycles.
    task automatic capture(input int idx, output logic [22:0] en_v, output logic [22:0] dat_v);
        for (int i = 0; i < SHIFT_CYC; i++) begin
            tick();
            en_v[i]  = progen[idx];
            dat_v[i] = progdata;
        end
    endtask

    function automatic logic [22:0] exp_en();
        return {1'b1, 1'b0, {10{1'b1}}, 1'b0, {10{1'b1}}};
    endfunction

    function automatic logic [22:0] exp_data(input logic [7:0] m, input logic [7:0] d);
        return {1'b0, 1'b0, m, 1'b1, 1'b1, 1'b0, d, 1'b0, 1'b1};
    endfunction

    function automatic exp_t mk(input logic [NUM_DCM-1:0] oh, input logic e);
        exp_t r;
        r.onehot = oh;
        r.err    = e;
        return r;
    endfunction

    initial begin
        logic [22:0] en_v;
        logic [22:0] dat_v;
        int          n;

        rst       = 1'b1;
        req       = '0;
        mul_m1    = '0;
        div_m1    = '0;
        progdone  = '0;
        locked    = '0;
        ack_seen  = 1'b0;
        progen_or = '0;

        // Reset state
        tick();
        tick();
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_progen", 32'(progen), 0);
        check("rst_progdata", 32'(progdata), 0);
        rst = 1'b0;
        tick();

        // Single request on DCM 0, M-1=2, D-1=3, explicit DONE/LOCK timing
        mul_m1[7:0] = 8'h02;
        div_m1[7:0] = 8'h03;
        sb_q.push_back(mk(2'b01, 1'b0));
        req = 2'b01;
        capture(0, en_v, dat_v);
        check("t1_stream_en", 32'(en_v), 32'(exp_en()));
        check("t1_stream_data", 32'(dat_v), 32'(exp_data(8'h02, 8'h03)));
        check("t1_busy", 32'(busy), 1);
        for (int i = 0; i < 5; i++) tick();
        progdone = 2'b01;
        tick();
        progdone = 2'b00;
        locked   = 2'b01;
        wait_ack("t1", 5, n);
        check("t1_ack_latency", 32'(n), 1);
        check("t1_busy_in_ack", 32'(busy), 1);
        req = 2'b00;
        tick();
        check("t1_busy_after", 32'(busy), 0);
        locked = 2'b00;

        // Round robin from pointer 0; requests held so the pointer decides
        rst = 1'b1;
        tick();
        rst = 1'b0;
        progdone = 2'b11;
        locked   = 2'b11;
        mul_m1   = {8'h10, 8'h20};
        div_m1   = {8'h01, 8'h02};
        sb_q.push_back(mk(2'b01, 1'b0));
        sb_q.push_back(mk(2'b10, 1'b0));
        sb_q.push_back(mk(2'b01, 1'b0));
        req = 2'b11;
        wait_ack("rr_first", 40, n);
        check("rr_first_lat", 32'(n), 26);
        wait_ack("rr_second", 40, n);
        check("rr_second_lat", 32'(n), 27);
        wait_ack("rr_third", 40, n);
        check("rr_third_lat", 32'(n), 27);
        req = 2'b00;
        tick();

        // Illegal M-1 on requester 1: immediate error ack, no PROGEN
        mul_m1[15:8] = 8'h00;
        progen_or = '0;
        sb_q.push_back(mk(2'b10, 1'b1));
        req = 2'b10;
        wait_ack("bad_mul", 3, n);
        check("bad_mul_lat", 32'(n), 1);
        req = 2'b00;
        tick();
        check("bad_mul_progen", 32'(progen_or), 0);
        check("bad_mul_busy", 32'(busy), 0);

        // Watchdog: PROGDONE never arrives
        progdone = 2'b00;
        locked   = 2'b00;
        mul_m1[7:0] = 8'h05;
        sb_q.push_back(mk(2'b01, 1'b1));
        req = 2'b01;
        wait_ack("wdog", 60, n);
        check("wdog_lat", 32'(n), SHIFT_CYC + 1 + (2**TIMEOUT_W - 1));
        req = 2'b00;
        tick();

        // Async reset during LOAD_M, request held, full stream replays
        progdone = 2'b11;
        locked   = 2'b11;
        mul_m1[7:0] = 8'h02;
        div_m1[7:0] = 8'h03;
        sb_q.push_back(mk(2'b01, 1'b0));
        req = 2'b01;
        for (int i = 0; i < 15; i++) tick();
        check("rstm_progen_pre", 32'(progen), 1);
        rst = 1'b1;
        #1;
        check("rstm_progen", 32'(progen), 0);
        check("rstm_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        capture(0, en_v, dat_v);
        check("rstm_stream_en", 32'(en_v), 32'(exp_en()));
        check("rstm_stream_data", 32'(dat_v), 32'(exp_data(8'h02, 8'h03)));
        wait_ack("rstm", 10, n);
        check("rstm_lat", 32'(n), 3);
        req = 2'b00;
        tick();

        // Grantee drops req during LOAD_D: sequence completes, no regrant
        mul_m1[15:8] = 8'h05;
        div_m1[15:8] = 8'h07;
        sb_q.push_back(mk(2'b10, 1'b0));
        req = 2'b10;
        for (int i = 0; i < 3; i++) tick();
        req = 2'b00;
        wait_ack("drop", 40, n);
        check("drop_lat", 32'(n), 23);
        progen_or = '0;
        for (int i = 0; i < 30; i++) tick();
        check("drop_no_regrant", 32'(progen_or), 0);
        check("drop_busy", 32'(busy), 0);

        check("sb_empty", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
